cnn_axis_ingest: RTL and testbench

AXI4-Stream slave ingest stage that sits directly upstream of the FSM/timer control pair and supplies its `Din_Valid` strobe and pixel data. Accepts feature-map pixels from the DMA and buffers them in a small first-word-fall-through FIFO. Enforces a fixed frame length of `FRAME_LEN` beats: short frames are zero-padded and over-long frames are truncated. Downstream therefore always sees exactly `FRAME_LEN` beats per frame, with the last beat marked.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/cnn_sync_fifo.sv | 62 ++++++
 rtl/cnn_axis_ingest.sv | 142 ++++++++++++++
 tb/tb_cnn_axis_ingest.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN streaming front end.
// The state encodings are also published as plain vectors for stages that store state as logic.
package cnn_pkg;

    localparam int FRAME_LEN_DEFAULT = 784;
    localparam int PIX_W             = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAD     = 2'd1,
        ST_DISCARD = 2'd2
    } ingest_state_t;

    localparam logic [1:0] S_RUN     = ST_RUN;
    localparam logic [1:0] S_PAD     = ST_PAD;
    localparam logic [1:0] S_DISCARD = ST_DISCARD;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible on rdata whenever not empty.
// rdata reads as zero while empty so downstream never sees stale entries.
module cnn_sync_fifo
    import cnn_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == {(AW+1){1'b0}});
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = empty ? {WIDTH{1'b0}} : r_mem[r_rptr];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cnn_axis_ingest.sv
// AXI4-Stream ingest: buffers pixels and forces every frame to exactly FRAME_LEN beats,
// zero-padding short frames and dropping the tail of long ones.
module cnn_axis_ingest
    import cnn_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic              S_AXIS_ACLK,
    input  logic              S_AXIS_ARESET,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic              S_AXIS_TLAST,
    output logic [DATA_W-1:0] Din,
    output logic              Din_Valid,
    input  logic              Din_Ready,
    output logic              Din_Last,
    output logic              Frame_Done,
    output logic              Frame_Err
);

    localparam int              CW       = clog2(FRAME_LEN);
    localparam logic [CW-1:0]   LAST_IDX = CW'(FRAME_LEN - 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_in_cnt;
    logic              r_err;
    logic              r_done;

    logic [1:0]        w_nxt_state;
    logic [CW-1:0]     w_nxt_cnt;
    logic              w_err;
    logic              w_push;
    logic [DATA_W:0]   w_wdata;
    logic [DATA_W:0]   w_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_acc;
    logic              w_at_last;

    // TREADY depends only on registered state so a pop never opens a slot in the same cycle.
    assign S_AXIS_TREADY = ~S_AXIS_ARESET &
                           (((r_state == S_RUN) & ~w_full) | (r_state == S_DISCARD));
    assign w_acc     = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_at_last = (r_in_cnt == LAST_IDX);
    assign w_pop     = Din_Ready & ~w_empty;

    assign Din        = w_rdata[DATA_W-1:0];
    assign Din_Last   = w_rdata[DATA_W];
    assign Din_Valid  = ~w_empty;
    assign Frame_Done = r_done;
    assign Frame_Err  = r_err;

    // Frame-length enforcement: next state, beat counter, FIFO write and error strobe.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_in_cnt;
        w_err       = 1'b0;
        w_push      = 1'b0;
        w_wdata     = {w_at_last, S_AXIS_TDATA};
        case (r_state)
            S_RUN: begin
                if (w_acc) begin
                    w_push = 1'b1;
                    if (S_AXIS_TLAST && !w_at_last) begin
                        w_err       = 1'b1;
                        w_nxt_cnt   = r_in_cnt + CW'(1);
                        w_nxt_state = S_PAD;
                    end else if (w_at_last && !S_AXIS_TLAST) begin
                        w_err       = 1'b1;
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = S_DISCARD;
                    end else if (w_at_last) begin
                        w_nxt_cnt = {CW{1'b0}};
                    end else begin
                        w_nxt_cnt = r_in_cnt + CW'(1);
                    end
                end else begin
                    w_push = 1'b0;
                end
            end
            S_PAD: begin
                w_wdata = {w_at_last, {DATA_W{1'b0}}};
                if (!w_full) begin
                    w_push = 1'b1;
                    if (w_at_last) begin
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = S_RUN;
                    end else begin
                        w_nxt_cnt = r_in_cnt + CW'(1);
                    end
                end else begin
                    w_push = 1'b0;
                end
            end
            S_DISCARD: begin
                if (w_acc && S_AXIS_TLAST) begin
                    w_nxt_state = S_RUN;
                end else begin
                    w_nxt_state = S_DISCARD;
                end
            end
            default: begin
                w_nxt_state = S_RUN;
                w_nxt_cnt   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and one-cycle status pulses.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state  <= S_RUN;
            r_in_cnt <= {CW{1'b0}};
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_in_cnt <= w_nxt_cnt;
            r_err    <= w_err;
            r_done   <= w_pop & w_rdata[DATA_W];
        end
    end

    cnn_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (S_AXIS_ACLK),
        .rst   (S_AXIS_ARESET),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_cnn_axis_ingest.sv
// Scoreboard bench for cnn_axis_ingest: a frame-level reference model predicts output beats
// and pulse counts, and a monitor compares every downstream handshake against it.
module tb_cnn_axis_ingest;

    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int FL  = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [DW-1:0] tdata     = 16'h0;
    logic          tvalid    = 1'b0;
    logic          tlast     = 1'b0;
    logic          din_ready = 1'b0;
    logic          tready;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_last;
    logic          done;
    logic          err;

    int            n_chk     = 0;
    int            n_pass    = 0;
    int            cur_len   = 0;
    int            exp_err   = 0;
    int            exp_done  = 0;
    int            seen_err  = 0;
    int            seen_done = 0;
    int            n_acc     = 0;
    int            rdy_mode  = 1;
    logic [DW:0]   exp_q[$];
    logic          held_v    = 1'b0;
    logic [DW:0]   held      = 17'h0;

    cnn_axis_ingest #(.DATA_W(DW), .DEPTH(DEP), .FRAME_LEN(FL)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .S_AXIS_TLAST  (tlast),
        .Din           (din),
        .Din_Valid     (din_valid),
        .Din_Ready     (din_ready),
        .Din_Last      (din_last),
        .Frame_Done    (done),
        .Frame_Err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference rule: each TLAST-delimited input frame becomes exactly FL output beats.
    task automatic model_beat(input logic [DW-1:0] d, input logic l);
        if (cur_len < FL) exp_q.push_back({cur_len == FL - 1, d});
        if (cur_len == FL - 1 && !l) exp_err++;
        if (l) begin
            if (cur_len < FL - 1) begin
                exp_err++;
                for (int i = cur_len + 1; i < FL; i++) exp_q.push_back({i == FL - 1, 16'h0000});
            end
            cur_len = 0;
        end else begin
            cur_len++;
        end
    endtask

    // Downstream ready pattern.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       din_ready = 1'b0;
            1:       din_ready = 1'b1;
            default: din_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: check output handshakes, then feed accepted input beats to the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_len = 0;
            held_v  = 1'b0;
        end else begin
            if (held_v) chk("din_hold", {din_valid, din_last, din}, {1'b1, held});
            if (din_valid && din_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got 0x%0h expected no beat", {din_last, din});
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("dout", {15'h0, din_last, din}, {15'h0, e});
                    if (e[DW]) exp_done++;
                end
            end
            held_v = din_valid && !din_ready;
            held   = {din_last, din};
            if (tvalid && tready) begin
                n_acc++;
                model_beat(tdata, tlast);
            end
            if (err)  seen_err++;
            if (done) seen_done++;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok = 1'b0;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = tready;
        end
        if (!ok) chk("send_timeout", {31'h0, ok}, 32'd1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({nm, "_drained"}, exp_q.size(), 32'd0);
        chk({nm, "_err_cnt"}, seen_err, exp_err);
        chk({nm, "_done_cnt"}, seen_done, exp_done);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int len;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", tready, 32'd0);
        chk("rst_valid", din_valid, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_last", din_last, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", tready, 32'd1);
        @(posedge clk); #1;

        // Nominal frame.
        for (int i = 0; i < 4; i++) send(16'h11 + 16'(i), i == 3);
        drain("nominal");

        // Backpressure: FIFO fills after DEPTH beats, then releases in order.
        rdy_mode = 0;
        @(posedge clk); #1;
        base = n_acc;
        fork
            for (int i = 0; i < 6; i++) send(16'h21 + 16'(i), i == 3);
            begin
                repeat (15) @(negedge clk);
                chk("bp_tready", tready, 32'd0);
                chk("bp_accepted", n_acc - base, 32'd4);
                rdy_mode = 1;
            end
        join
        send(16'h27, 1'b0);
        send(16'h28, 1'b1);
        drain("backpressure");

        // Early TLAST: two pad cycles with TREADY low, one error pulse.
        send(16'hA1, 1'b0);
        send(16'hA2, 1'b1);
        @(negedge clk);
        chk("early_err_pulse", err, 32'd1);
        chk("pad_tready_0", tready, 32'd0);
        @(negedge clk);
        chk("pad_tready_1", tready, 32'd0);
        chk("early_err_single", err, 32'd0);
        @(posedge clk); #1;
        drain("early_tlast");

        // Missing TLAST, then a clean frame.
        for (int i = 0; i < 6; i++) send(16'hB1 + 16'(i), i == 5);
        for (int i = 0; i < 4; i++) send(16'hC1 + 16'(i), i == 3);
        drain("missing_tlast");

        // Reset mid-frame.
        rdy_mode = 0;
        send(16'hD1, 1'b0);
        send(16'hD2, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", din_valid, 32'd0);
        chk("midrst_done", done, 32'd0);
        chk("midrst_err", err, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send(16'hE1 + 16'(i), i == 3);
        drain("reset_midframe");

        // Randomized frames of length 1..6 with random downstream stalls.
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                send(16'($urandom), i == len - 1);
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk); #1;
                end
            end
        end
        rdy_mode = 1;
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
